// File: rtl/trigger_engine.sv
// Per-channel threshold trigger: edge/saturation detect -> IDLE/ACTIVE/EXTEND window FSM.
// TRIGGER rises 2 beats after the hitting beat, SATURATION_FLAG 3 beats; no backpressure (valid only gates window start/hold).
module trigger_engine #(
  parameter int CH_NUM                      = 2,
  parameter int SAMPLE_NUM_PER_CLK          = 8,
  parameter int SAMPLE_WIDTH                = 16,
  parameter int ADC_RESOLUTION_WIDTH        = 12,
  parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int MAX_POST_ACQUISITION_LENGTH = 2,
  parameter int MAX_TRIGGER_LENGTH          = 64
) (
  input  logic                                                ACLK,
  input  logic                                                ARESET,
  input  logic                                                SET_CONFIG,
  input  logic                                                STOP,
  input  logic [CH_NUM*SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [CH_NUM-1:0]                                   S_AXIS_TVALID,
  input  logic [CH_NUM*SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0]   H_S_AXIS_TDATA,
  input  logic [CH_NUM*SAMPLE_WIDTH-1:0]                      RISING_EDGE_THRESHOLD,
  input  logic [CH_NUM*SAMPLE_WIDTH-1:0]                      FALLING_EDGE_THRESHOLD,
  input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0]         PRE_ACQUISITION_LENGTH,
  input  logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0]        POST_ACQUISITION_LENGTH,
  input  logic [ADC_RESOLUTION_WIDTH-1:0]                     MODE_SWITCH_UPPER_THRESHOLD,
  input  logic [ADC_RESOLUTION_WIDTH-1:0]                     MODE_SWITCH_LOWER_THRESHOLD,
  output logic [CH_NUM-1:0]                                   TRIGGER,
  output logic [CH_NUM-1:0]                                   SATURATION_FLAG,
  output logic [CH_NUM-1:0]                                   TRUNCATED,
  output logic [CH_NUM*16-1:0]                                TRIGGER_COUNT
);
  localparam int SPC   = SAMPLE_NUM_PER_CLK;
  localparam int SW    = SAMPLE_WIDTH;
  localparam int ADC   = ADC_RESOLUTION_WIDTH;
  localparam int MPRE  = MAX_PRE_ACQUISITION_LENGTH;
  localparam int MPOST = MAX_POST_ACQUISITION_LENGTH;
  localparam int EXT_W = $clog2(MPRE + MPOST + 1) + 1;
  localparam int LEN_W = $clog2(MAX_TRIGGER_LENGTH) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, EXTEND} state_t;

  logic [EXT_W-1:0]      pre_c, post_c, ext_total;
  logic signed [ADC-1:0] sat_hi, sat_lo;
  logic                  unused_hg_bits;

  always_comb begin
    pre_c     = (int'(PRE_ACQUISITION_LENGTH) > MPRE) ? EXT_W'(MPRE) : EXT_W'(PRE_ACQUISITION_LENGTH);
    post_c    = (int'(POST_ACQUISITION_LENGTH) > MPOST) ? EXT_W'(MPOST) : EXT_W'(POST_ACQUISITION_LENGTH);
    ext_total = pre_c + post_c;
  end

  assign sat_hi = $signed(MODE_SWITCH_UPPER_THRESHOLD);
  assign sat_lo = $signed(MODE_SWITCH_LOWER_THRESHOLD);
  // Only the MSB-aligned ADC field of each high-gain sample is meaningful.
  assign unused_hg_bits = ^H_S_AXIS_TDATA;

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    logic signed [SW-1:0]  rise_th, fall_th, prev_last, cur, prv;
    logic signed [ADC-1:0] hg;
    logic                  rise_any, fall_all, sat_any;
    logic                  hit_start, hit_end, valid_q, sat_d1, sat_d2, sat_q;
    logic                  armed, trig_q, trunc_q, start_ok, tail_zero;
    state_t                state, exit_state;
    logic [LEN_W-1:0]      len_cnt;
    logic [EXT_W-1:0]      ext_cnt;
    logic [15:0]           count, count_inc;

    assign rise_th = $signed(RISING_EDGE_THRESHOLD[ch*SW +: SW]);
    assign fall_th = $signed(FALLING_EDGE_THRESHOLD[ch*SW +: SW]);

    always_comb begin
      rise_any = 1'b0;
      fall_all = 1'b1;
      sat_any  = 1'b0;
      prv      = prev_last;
      cur      = '0;
      hg       = '0;
      for (int k = 0; k < SPC; k++) begin
        cur = $signed(S_AXIS_TDATA[(ch*SPC+k)*SW +: SW]);
        hg  = $signed(H_S_AXIS_TDATA[(ch*SPC+k)*SW + SW - ADC +: ADC]);
        if (cur > rise_th && !(prv > rise_th)) rise_any = 1'b1;
        if (!(cur < fall_th))                  fall_all = 1'b0;
        if (hg >= sat_hi || hg <= sat_lo)      sat_any  = 1'b1;
        prv = cur;
      end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        prev_last <= '0; hit_start <= 1'b0; hit_end <= 1'b0; valid_q <= 1'b0;
        sat_d1 <= 1'b0; sat_d2 <= 1'b0; sat_q <= 1'b0;
      end else if (SET_CONFIG) begin
        prev_last <= '0; hit_start <= 1'b0; hit_end <= 1'b0; valid_q <= 1'b0;
        sat_d1 <= 1'b0; sat_d2 <= 1'b0; sat_q <= 1'b0;
      end else begin
        prev_last <= $signed(S_AXIS_TDATA[(ch*SPC+SPC-1)*SW +: SW]);
        hit_start <= rise_any | sat_any;
        hit_end   <= fall_all;
        valid_q   <= S_AXIS_TVALID[ch];
        sat_d1    <= sat_any;
        sat_d2    <= sat_d1;
        sat_q     <= sat_d2;
      end
    end

    assign start_ok   = hit_start & valid_q & ~STOP & armed;
    assign tail_zero  = (ext_total == '0);
    assign exit_state = tail_zero ? IDLE : EXTEND;
    assign count_inc  = (count == 16'hFFFF) ? count : count + 16'd1;

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        state <= IDLE; armed <= 1'b1; trig_q <= 1'b0; trunc_q <= 1'b0;
        len_cnt <= '0; ext_cnt <= '0; count <= '0;
      end else if (SET_CONFIG) begin
        state <= IDLE; armed <= 1'b1; trig_q <= 1'b0; trunc_q <= 1'b0;
        len_cnt <= '0; ext_cnt <= '0; count <= '0;
      end else begin
        trunc_q <= 1'b0;
        if (hit_end) armed <= 1'b1;
        case (state)
          IDLE: if (start_ok) begin
            state <= ACTIVE; trig_q <= 1'b1; len_cnt <= '0; count <= count_inc;
          end
          ACTIVE: begin
            // A forced truncation disarms until the signal falls back below threshold.
            if (len_cnt == LEN_W'(MAX_TRIGGER_LENGTH - 1)) begin
              trunc_q <= 1'b1; armed <= 1'b0;
              state <= exit_state; trig_q <= ~tail_zero; ext_cnt <= '0;
            end else if ((hit_end | ~valid_q) & ~(hit_start & hit_end)) begin
              state <= exit_state; trig_q <= ~tail_zero; ext_cnt <= '0;
            end else begin
              len_cnt <= len_cnt + LEN_W'(1);
            end
          end
          EXTEND: begin
            if (start_ok) begin
              state <= ACTIVE; len_cnt <= '0; count <= count_inc;
            end else if (ext_cnt == ext_total - EXT_W'(1)) begin
              state <= IDLE; trig_q <= 1'b0;
            end else begin
              ext_cnt <= ext_cnt + EXT_W'(1);
            end
          end
          default: begin state <= IDLE; trig_q <= 1'b0; end
        endcase
      end
    end

    assign TRIGGER[ch]               = trig_q;
    assign TRUNCATED[ch]             = trunc_q;
    assign SATURATION_FLAG[ch]       = sat_q;
    assign TRIGGER_COUNT[ch*16 +: 16] = count;
  end
endmodule
